// File: rtl/six_bit_add_if.sv
// Operand/result bundle for six_bit_add.
// Optional macro SIXBITADD_OVF_EN adds the registered signed-overflow flag ovf.
// master: the block supplying operands and consuming results.
// slave:  the adder itself.
interface six_bit_add_if #(
   parameter int WIDTH = 6
);
   logic [WIDTH-1:0] ain;
   logic [WIDTH-1:0] bin;
   logic [WIDTH-1:0] sum;
   logic             cout;
`ifdef SIXBITADD_OVF_EN
   logic             ovf;

   modport master (
      output ain,
      output bin,
      input  sum,
      input  cout,
      input  ovf
   );

   modport slave (
      input  ain,
      input  bin,
      output sum,
      output cout,
      output ovf
   );
`else
   modport master (
      output ain,
      output bin,
      input  sum,
      input  cout
   );

   modport slave (
      input  ain,
      input  bin,
      output sum,
      output cout
   );
`endif
endinterface

// File: rtl/six_bit_add.sv
// six_bit_add: registered unsigned adder, {cout,sum} = ain + bin.
// Ripple-carry chain of 1-bit full-adder cells feeding one output register.
// No carry-in (c[0] = 0), no enable: a new result is registered every cycle.
// Optional macro SIXBITADD_OVF_EN adds ovf = c[WIDTH] ^ c[WIDTH-1], registered
// alongside sum/cout.
module six_bit_add #(
   parameter int WIDTH = 6
) (
   input  logic          clk,
   input  logic          rst_n,
   six_bit_add_if.slave  bus
);

   logic [WIDTH:0]   c;
   logic [WIDTH-1:0] s;

   // Ripple-carry chain: one full-adder cell per bit, carry rippling upward.
   always_comb begin
      c    = '0;
      s    = '0;
      c[0] = 1'b0;
      for (int i = 0; i < WIDTH; i++) begin
         s[i]   = bus.ain[i] ^ bus.bin[i] ^ c[i];
         c[i+1] = (bus.ain[i] & bus.bin[i]) | (c[i] & (bus.ain[i] ^ bus.bin[i]));
      end
   end

   // Output register: all outputs come from flops; async clear discards any result.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.sum  <= '0;
         bus.cout <= 1'b0;
      end else begin
         bus.sum  <= s;
         bus.cout <= c[WIDTH];
      end
   end

`ifdef SIXBITADD_OVF_EN
   // Two's-complement overflow: carry into the sign bit differs from carry out.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.ovf <= 1'b0;
      end else begin
         bus.ovf <= c[WIDTH] ^ c[WIDTH-1];
      end
   end
`endif

endmodule

// File: tb/tb_six_bit_add.sv
// Self-checking bench for six_bit_add. Expected {ovf,cout,sum} values are
// pushed to a queue when operands are driven (on the falling edge) and popped
// and compared on the following falling edge, one rising edge later.
module tb_six_bit_add;
   localparam int W = 6;

   logic clk = 1'b0;
   logic rst_n;

   six_bit_add_if #(.WIDTH(W)) bus ();

   six_bit_add #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   logic [W+1:0] q[$];   // {ovf, cout, sum}

   function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b);
      logic [W:0] t;
      logic       o;
      t = {1'b0, a} + {1'b0, b};
      o = 1'b0;
`ifdef SIXBITADD_OVF_EN
      o = (a[W-1] == b[W-1]) && (t[W-1] != a[W-1]);
`endif
      return {o, t};
   endfunction

   function automatic logic [W+1:0] obs();
      logic o;
      o = 1'b0;
`ifdef SIXBITADD_OVF_EN
      o = bus.ovf;
`endif
      return {o, bus.cout, bus.sum};
   endfunction

   task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b);
      bus.ain = a;
      bus.bin = b;
      q.push_back(model(a, b));
   endtask

   task automatic test_reset();
      logic [W+1:0] got;
      rst_n   = 1'b0;
      bus.ain = 6'd5;
      bus.bin = 6'd7;
      repeat (4) begin
         @(negedge clk);
         got = obs();
         checks++;
         if (got !== '0) begin
            errors++;
            $display("FAIL reset_hold got %h want %h", got, {(W+2){1'b0}});
         end
      end
      rst_n = 1'b1;
   endtask

   task automatic test_basic_add();
      logic [W+1:0] exp, got;
      @(negedge clk);
      drive(6'd5, 6'd7);
      @(negedge clk);
      exp = q.pop_front();
      got = obs();
      checks++;
      if (got !== exp || got[W:0] !== 7'd12) begin
         errors++;
         $display("FAIL basic_add got %h want %h", got, exp);
      end
   endtask

   task automatic test_wrap();
      logic [W-1:0] av[6] = '{6'd63, 6'd63, 6'd32, 6'd31, 6'd31, 6'd32};
      logic [W-1:0] bv[6] = '{6'd1,  6'd63, 6'd32, 6'd1,  6'd0,  6'd63};
      logic [W:0]   fixed[6] = '{7'h40, 7'h7e, 7'h40, 7'h20, 7'h1f, 7'h5f};
      logic [W+1:0] exp, got;
      int           k;
      k = 0;
      for (int i = 0; i <= 6; i++) begin
         @(negedge clk);
         if (q.size() > 0) begin
            exp = q.pop_front();
            got = obs();
            checks++;
            if (got !== exp || got[W:0] !== fixed[k]) begin
               errors++;
               $display("FAIL wrap[%0d] got %h want %h", k, got, exp);
            end
            k++;
         end
         if (i < 6) drive(av[i], bv[i]);
      end
   endtask

   task automatic test_latency();
      logic [W-1:0] av[3] = '{6'd1, 6'd3, 6'd10};
      logic [W-1:0] bv[3] = '{6'd2, 6'd4, 6'd20};
      logic [W+1:0] exp, got, prev;
      prev = obs();
      for (int i = 0; i <= 3; i++) begin
         @(negedge clk);
         if (q.size() > 0) begin
            exp = q.pop_front();
            got = obs();
            checks++;
            if (got !== exp) begin
               errors++;
               $display("FAIL latency_result[%0d] got %h want %h", i, got, exp);
            end
            prev = exp;
         end
         if (i < 3) begin
            drive(av[i], bv[i]);
            #1;
            got = obs();
            checks++;
            if (got !== prev) begin
               errors++;
               $display("FAIL latency_hold[%0d] got %h want %h", i, got, prev);
            end
         end
      end
   endtask

   task automatic test_exhaustive();
      logic [W+1:0] exp, got;
      int           bad;
      bad = 0;
      for (int a = 0; a < 64; a++) begin
         for (int b = 0; b < 64; b++) begin
            @(negedge clk);
            if (q.size() > 0) begin
               exp = q.pop_front();
               got = obs();
               checks++;
               if (got !== exp) begin
                  errors++;
                  if (bad < 10) $display("FAIL exhaustive got %h want %h", got, exp);
                  bad++;
               end
            end
            drive(a[W-1:0], b[W-1:0]);
         end
      end
      @(negedge clk);
      exp = q.pop_front();
      got = obs();
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL exhaustive_last got %h want %h", got, exp);
      end
   endtask

   task automatic test_async_reset();
      logic [W+1:0] exp, got;
      @(negedge clk);
      drive(6'd20, 6'd30);
      @(posedge clk);
      #2;
      exp = q.pop_front();
      got = obs();
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL async_pre got %h want %h", got, exp);
      end
      rst_n = 1'b0;
      #1;
      got = obs();
      checks++;
      if (got !== '0) begin
         errors++;
         $display("FAIL async_clear got %h want %h", got, {(W+2){1'b0}});
      end
      @(negedge clk);
      rst_n = 1'b1;
      drive(6'd33, 6'd44);
      @(negedge clk);
      exp = q.pop_front();
      got = obs();
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL async_recover got %h want %h", got, exp);
      end
   endtask

   initial begin
      test_reset();
      test_basic_add();
      test_wrap();
      test_latency();
      test_exhaustive();
      test_async_reset();
      if (q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_leftover got %0d want 0", q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
